// File: rtl/regfile_seq.sv
// Command sequencer for an external register file: LDI, MOV, SWAP and CLR.
// SWAP is built only when REGFILE_SEQ_SWAP_EN is defined; otherwise op 10 just pulses err.
module regfile_seq #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] rf_readnum,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  input  logic [DW-1:0] rf_data_out,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, CLR} state_t;

  localparam logic [1:0]    OP_LDI   = 2'b00;
  localparam logic [1:0]    OP_MOV   = 2'b01;
  localparam logic [1:0]    OP_SWAP  = 2'b10;
  localparam logic [1:0]    OP_CLR   = 2'b11;
  localparam logic [AW-1:0] CNT_LAST = '1;

  state_t        state_reg, state_next;
  logic [1:0]    op_reg;
  logic [AW-1:0] rd_reg, rs_reg, cnt_reg;
  logic [DW-1:0] imm_reg, tmp_a_reg, tmp_b_reg;
  logic          err_reg, err_next;
  logic          accept;

  assign cmd_ready = (state_reg == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign err       = err_reg;

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LDI:  state_next = WR1;
            OP_MOV:  state_next = RD1;
            OP_SWAP: begin
`ifdef REGFILE_SEQ_SWAP_EN
              state_next = RD1;
`else
              err_next = 1'b1;
`endif
            end
            OP_CLR:  state_next = CLR;
          endcase
        end
      end
`ifdef REGFILE_SEQ_SWAP_EN
      RD1: state_next = (op_reg == OP_SWAP) ? RD2 : WR1;
      WR1: state_next = (op_reg == OP_SWAP) ? WR2 : IDLE;
`else
      RD1: state_next = WR1;
      WR1: state_next = IDLE;
`endif
      RD2: state_next = WR1;
      WR2: state_next = IDLE;
      CLR: if (cnt_reg == CNT_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      rd_reg    <= '0;
      rs_reg    <= '0;
      imm_reg   <= '0;
      tmp_a_reg <= '0;
      tmp_b_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (accept) begin
        op_reg  <= cmd_op;
        rd_reg  <= cmd_rd;
        rs_reg  <= cmd_rs;
        imm_reg <= cmd_imm;
      end
      if (state_reg == RD1) tmp_a_reg <= rf_data_out;
      if (state_reg == RD2) tmp_b_reg <= rf_data_out;
      // Natural wrap of cnt leaves it at 0 for the next CLR.
      if (state_reg == CLR) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    rf_readnum  = '0;
    rf_writenum = '0;
    rf_write    = 1'b0;
    rf_data_in  = '0;
    done        = 1'b0;
    case (state_reg)
      RD1: rf_readnum = rs_reg;
      RD2: rf_readnum = rd_reg;
      WR1: begin
        rf_write    = 1'b1;
        rf_writenum = rd_reg;
        rf_data_in  = (op_reg == OP_LDI) ? imm_reg : tmp_a_reg;
        done        = (op_reg != OP_SWAP);
      end
      WR2: begin
        rf_write    = 1'b1;
        rf_writenum = rs_reg;
        rf_data_in  = tmp_b_reg;
        done        = 1'b1;
      end
      CLR: begin
        rf_write    = 1'b1;
        rf_writenum = cnt_reg;
        done        = (cnt_reg == CNT_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq: random commands against a register-array reference model,
// with an external register file model attached to the rf_* ports.
module tb_regfile_seq;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0;
  logic [AW-1:0] cmd_rs = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [AW-1:0] rf_readnum, rf_writenum;
  logic          rf_write;
  logic [DW-1:0] rf_data_in, rf_data_out;
  logic          done, err;

  always #5 clk = ~clk;

  regfile_seq #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_readnum(rf_readnum), .rf_writenum(rf_writenum), .rf_write(rf_write),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out),
    .done(done), .err(err)
  );

  // External register file
  logic [DW-1:0] mem [NR];
  logic [DW-1:0] init_val [NR];
  logic          init_mem = 1'b0;
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < NR; i++) mem[i] <= init_val[i];
    else if (rf_write) mem[rf_writenum] <= rf_data_in;
  end
  assign rf_data_out = mem[rf_readnum];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    int            num;
    logic [DW-1:0] data;
    bit            last;
    int            cyc;
  } exp_t;
  exp_t q[$];

  logic [DW-1:0] ref_rf [NR];
  int vectors = 0;
  int miscompares = 0;
  int last_n = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary_and_finish();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic timeout_abort(string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at cycle %0d", what, cyc);
    summary_and_finish();
  endtask

  task automatic push_w(int num, logic [DW-1:0] data, bit last, int c);
    exp_t e;
    e.is_err = 1'b0; e.num = num; e.data = data; e.last = last; e.cyc = c;
    q.push_back(e);
  endtask

  // Reference model: n is the cycle count seen when the command is presented;
  // the cycle right after the accepting edge is n+1.
  task automatic model_cmd(logic [1:0] op, int rd, int rs, logic [DW-1:0] imm, int n);
    logic [DW-1:0] a, b;
    exp_t e;
    case (op)
      2'b00: begin
        push_w(rd, imm, 1'b1, n + 1);
        ref_rf[rd] = imm;
      end
      2'b01: begin
        push_w(rd, ref_rf[rs], 1'b1, n + 2);
        ref_rf[rd] = ref_rf[rs];
      end
      2'b10: begin
`ifdef REGFILE_SEQ_SWAP_EN
        a = ref_rf[rs];
        b = ref_rf[rd];
        push_w(rd, a, 1'b0, n + 3);
        push_w(rs, b, 1'b1, n + 4);
        ref_rf[rd] = a;
        ref_rf[rs] = b;
`else
        a = '0; b = '0;
        e.is_err = 1'b1; e.num = 0; e.data = a | b; e.last = 1'b0; e.cyc = n + 1;
        q.push_back(e);
`endif
      end
      default: begin
        for (int i = 0; i < NR; i++) begin
          push_w(i, '0, (i == NR - 1), n + 1 + i);
          ref_rf[i] = '0;
        end
      end
    endcase
  endtask

  // Called right after a negedge; returns right after the negedge following acceptance.
  // noisy: 0 idle inputs while busy, 1 random garbage, 2 cmd_valid held high.
  task automatic issue(logic [1:0] op, int rd, int rs, logic [DW-1:0] imm, int noisy);
    int budget = 0;
    while (!cmd_ready) begin
      if (noisy == 0) cmd_valid = 1'b0;
      else cmd_valid = (noisy == 2) ? 1'b1 : 1'($urandom);
      cmd_op  = 2'($urandom);
      cmd_rd  = AW'($urandom);
      cmd_rs  = AW'($urandom);
      cmd_imm = DW'($urandom);
      @(negedge clk);
      budget++;
      if (budget > 40) timeout_abort("cmd_ready_wait");
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = AW'(rd);
    cmd_rs    = AW'(rs);
    cmd_imm   = imm;
    last_n    = cyc;
    model_cmd(op, rd, rs, imm, cyc);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or an error pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done && !rf_write) check("done_without_write", 32'(done), 32'(0));
    if (done || err) check("err_done_exclusive", 32'(err & done), 32'(0));
    if (rf_write || err) begin
      if (q.size() == 0) begin
        check("unexpected_activity", 32'({rf_write, err}), 32'(0));
      end else begin
        e = q.pop_front();
        check("event_kind_err", 32'(err), 32'(e.is_err));
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.is_err) begin
          check("writenum", 32'(rf_writenum), 32'(e.num));
          check("data_in", 32'(rf_data_in), 32'(e.data));
          check("done_on_write", 32'(done), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #200000;
    timeout_abort("global_watchdog");
  end

  initial begin
    logic [DW-1:0] saved [NR];
    int guard;
    int op_sel;

    for (int i = 0; i < NR; i++) begin
      init_val[i] = DW'($urandom);
      ref_rf[i]   = init_val[i];
    end
    init_mem = 1'b1;
    @(negedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_rf_write", 32'(rf_write), 32'(0));
    check("rst_rf_data_in", 32'(rf_data_in), 32'(0));
    check("rst_rf_readnum", 32'(rf_readnum), 32'(0));
    check("rst_rf_writenum", 32'(rf_writenum), 32'(0));
    check("rst_done_err", 32'({done, err}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // LDI r3 = 0x00A5, ready back the cycle after done
    issue(2'b00, 3, 0, 16'h00A5, 0);
    check("ldi_busy_in_wr1", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    check("ldi_ready_back", 32'(cmd_ready), 32'(1));

    // MOV r6 <- r1
    issue(2'b00, 1, 0, 16'h1234, 0);
    issue(2'b01, 6, 1, '0, 0);
    check("mov_rd1_readnum", 32'(rf_readnum), 32'(1));

    // SWAP r5 <-> r2
    issue(2'b00, 2, 0, 16'h0002, 0);
    issue(2'b00, 5, 0, 16'h0005, 0);
    issue(2'b10, 5, 2, '0, 0);
`ifdef REGFILE_SEQ_SWAP_EN
    check("swap_rd1_readnum", 32'(rf_readnum), 32'(2));
    @(negedge clk);
    check("swap_rd2_readnum", 32'(rf_readnum), 32'(5));
`else
    check("swap_disabled_err", 32'(err), 32'(1));
    check("swap_disabled_ready", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    check("swap_disabled_err_one_cycle", 32'(err), 32'(0));
`endif

    // Same-register SWAP and MOV
    issue(2'b10, 4, 4, '0, 1);
    issue(2'b01, 7, 7, '0, 1);

    // Full CLR over nonzero contents with cmd_valid held high while busy
    for (int i = 0; i < NR; i++) issue(2'b00, i, 0, DW'($urandom_range(1, 16'hFFFF)), 1);
    issue(2'b11, 0, 0, '0, 2);

    // Reset in the middle of CLR while writenum=3 is presented
    for (int i = 0; i < NR; i++) issue(2'b00, i, 0, DW'($urandom_range(1, 16'hFFFF)), 1);
    for (int i = 0; i < NR; i++) saved[i] = ref_rf[i];
    issue(2'b11, 0, 0, '0, 2);
    guard = 0;
    while (cyc != last_n + 4) begin
      @(negedge clk);
      guard++;
      if (guard > 20) timeout_abort("clr_index3_wait");
    end
    check("clr_at_index3", 32'(rf_writenum), 32'(3));
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_rf_write", 32'(rf_write), 32'(0));
    check("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("midrst_done", 32'(done), 32'(0));
    for (int i = 0; i < NR; i++) ref_rf[i] = (i < 3) ? '0 : saved[i];
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) check("midrst_reg_contents", 32'(mem[i]), 32'(ref_rf[i]));

    // Randomized commands
    for (int k = 0; k < 120; k++) begin
      op_sel = int'($urandom_range(0, 9));
      if (op_sel < 4)       issue(2'b00, int'($urandom_range(0, NR - 1)), 0, DW'($urandom), 1);
      else if (op_sel < 7)  issue(2'b01, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)), DW'($urandom), 1);
      else if (op_sel < 9)  issue(2'b10, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)), DW'($urandom), 1);
      else                  issue(2'b11, int'($urandom_range(0, NR - 1)), 0, DW'($urandom), 1);
    end

    guard = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 40) timeout_abort("scoreboard_drain");
    end
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'(0));
    for (int i = 0; i < NR; i++) check("final_reg_contents", 32'(mem[i]), 32'(ref_rf[i]));
    summary_and_finish();
  end

endmodule
